lcd_cls_cmd_sequencer: RTL
==========================

// Module: lcd_cls_cmd_sequencer
// PURPOSE
//  Downstream of the LCD text feed FSM. Accepts one-cycle-qualified clear / write-line-1 / write-line-2
//  requests, then serialises each into a PMOD CLS escape-sequence byte stream to the SPI byte
//  transmitter. Returns command-ready to the feed FSM only after the final byte has left the wire.
//  All sequential logic advances only on i_ce_2_5mhz cycles.
// PARAMETERS
//  parm_line_len      16  characters per LCD line; text ports are 8*parm_line_len bits wide
//  parm_byte_gap       4  idle CE ticks inserted after each accepted byte (CLS inter-byte spacing)
// PORTS
//  i_clk_20mhz           in   1    system clock; the single clock of the block
//  i_rst_20mhz           in   1    synchronous, active-high reset
//  i_ce_2_5mhz           in   1    clock enable; FSM, counters and handshakes advance only when high
//  i_lcd_wr_clear_display in  1    request: clear display
//  i_lcd_wr_text_line1   in   1    request: write line 1
//  i_lcd_wr_text_line2   in   1    request: write line 2
//  i_dat_ascii_line1     in   128  line-1 text; [127:120] is the leftmost char
//  i_dat_ascii_line2     in   128  line-2 text; same ordering
//  o_lcd_command_ready   out  1    high = idle, able to accept a request
//  o_tx_byte             out  8    byte offered to the SPI transmitter
//  o_tx_valid            out  1    o_tx_byte is valid
//  i_tx_ready            in   1    SPI transmitter can take a byte
//  i_tx_idle             in   1    SPI transmitter shift register empty, CS deasserted
// BEHAVIOUR
//  Reset: state ST_IDLE; o_lcd_command_ready=1; o_tx_valid=0; o_tx_byte=8'h00; counters=0; text regs=0.
//  Priority when several requests are high on one CE cycle: clear > line1 > line2.
//  Requests are ignored unless the state is ST_IDLE.
//  Acceptance (ST_IDLE, CE high, any request high):
//   - latch the command code and the selected line text;
//   - clear the byte index and the sequence length;
//   - o_lcd_command_ready falls on the next CE cycle and stays low until the return to ST_IDLE.
//  Byte sequences:
//   - clear = 1B 5B 6A (3 bytes);
//   - line1 = 1B 5B 30 3B 30 48 followed by 16 text bytes (22 bytes);
//   - line2 = 1B 5B 31 3B 30 48 followed by 16 text bytes (22 bytes).
//  States:
//   - ST_IDLE -> ST_SEND on acceptance.
//   - ST_SEND: o_tx_valid=1 and o_tx_byte = seq[idx], both held stable until a CE cycle where
//     i_tx_ready=1. That cycle is the transfer.
//   - After a transfer: idx+1, then ST_GAP. If idx was the last index, go to ST_DRAIN instead.
//   - ST_GAP: o_tx_valid=0. Count parm_byte_gap CE ticks, then ST_SEND. A gap of 0 goes
//     ST_SEND -> ST_SEND directly.
//   - ST_DRAIN: o_tx_valid=0. Wait for i_tx_idle=1 on a CE cycle, then ST_IDLE with ready=1.
//  Handshake rules:
//   - o_tx_valid never drops without a transfer.
//   - o_tx_byte never changes while o_tx_valid=1 and no transfer has occurred.
//  Counter widths: idx is 5 bits, max 21, no wrap; gap counter is $clog2(parm_byte_gap+1) bits.
//  Text changes after acceptance do not affect an in-flight sequence.
//  CE low: all registers hold; outputs stable.
//  i_tx_ready=1 with o_tx_valid=0: no effect.
//  i_tx_idle is sampled only in ST_DRAIN.
//  Reset mid-sequence: immediate return to reset values on the next clock edge, regardless of CE.
//   A partly sent escape sequence is abandoned; the feed FSM's next clear restores the display.
// STRUCTURE
//  Package lcd_cls_pkg holds:
//   - t_cls_seq_state enum {ST_IDLE, ST_SEND, ST_GAP, ST_DRAIN};
//   - t_cls_cmd enum {CMD_CLEAR, CMD_LINE1, CMD_LINE2};
//   - constants c_esc=8'h1B, c_lbr=8'h5B, c_clr=8'h6A, c_seq_len_clear=3, c_seq_len_line=22.
//  Sub-module lcd_cls_seq_rom: combinational (cmd, idx, text) -> byte.
//  Top-level module: FSM, counters, latches, handshake.
// TESTING
//  1. Reset, then clear pulse with i_tx_ready=1 and i_tx_idle=1:
//     -> ready low after 1 CE; bytes 1B,5B,6A sent; 4-tick gaps; ready high after drain.
//  2. line1 with text "ACL X:+0.12g    ":
//     -> 22 bytes 1B 5B 30 3B 30 48 41 43 4C 20 58 ..., in order, one per transfer.
//  3. Backpressure: hold i_tx_ready=0 for 10 CE cycles mid-line2.
//     -> o_tx_valid stays 1; o_tx_byte is stable; no byte skipped or duplicated.
//  4. Clear+line1+line2 all asserted together -> only the clear sequence is emitted.
//     Request during busy -> ignored.
//  5. Drain: i_tx_idle=0 for 50 CE after the last byte -> ready stays low until i_tx_idle=1.
//  6. Reset asserted at byte 10 of a line write -> next edge: valid=0, ready=1, state ST_IDLE.
//     A following clear then completes normally.

Source files
------------

// File: rtl/lcd_cls_cmd_sequencer_pkg.sv
// Shared types and PMOD CLS escape-sequence constants for the LCD command sequencer.
package lcd_cls_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DRAIN
    } t_cls_seq_state;

    typedef enum logic [1:0] {
        CMD_CLEAR,
        CMD_LINE1,
        CMD_LINE2
    } t_cls_cmd;

    localparam logic [7:0] c_esc  = 8'h1B;
    localparam logic [7:0] c_lbr  = 8'h5B;
    localparam logic [7:0] c_clr  = 8'h6A;
    localparam logic [7:0] c_row1 = 8'h30;
    localparam logic [7:0] c_row2 = 8'h31;
    localparam logic [7:0] c_semi = 8'h3B;
    localparam logic [7:0] c_col0 = 8'h30;
    localparam logic [7:0] c_home = 8'h48;

    localparam int c_seq_len_clear = 3;
    localparam int c_seq_len_line  = 22;
    localparam int c_hdr_len_line  = 6;

    // Index of the final byte for a command; idx never advances past it.
    function automatic logic [4:0] seq_last_idx(t_cls_cmd cmd, int line_len);
        if (cmd == CMD_CLEAR)
            return 5'(c_seq_len_clear - 1);
        return 5'(c_hdr_len_line + line_len - 1);
    endfunction

endpackage

// File: rtl/lcd_cls_cmd_sequencer_if.sv
// Byte stream toward the SPI byte transmitter: valid/ready plus transmitter-idle status.
interface lcd_cls_cmd_sequencer_if;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_idle;

    modport master (
        output tx_byte,
        output tx_valid,
        input  tx_ready,
        input  tx_idle
    );

    modport slave (
        input  tx_byte,
        input  tx_valid,
        output tx_ready,
        output tx_idle
    );
endinterface

// File: rtl/lcd_cls_cmd_sequencer_rom.sv
// Combinational lookup of the escape-sequence byte at a given index for a latched command.
module lcd_cls_seq_rom
    import lcd_cls_pkg::*;
#(
    parameter int parm_line_len = 16
) (
    input  t_cls_cmd                     i_cmd,
    input  logic [4:0]                   i_idx,
    input  logic [8*parm_line_len-1:0]   i_text,
    output logic [7:0]                   o_byte
);

    always_comb begin
        o_byte = 8'h00;
        if (i_cmd == CMD_CLEAR) begin
            case (i_idx)
                5'd0:    o_byte = c_esc;
                5'd1:    o_byte = c_lbr;
                5'd2:    o_byte = c_clr;
                default: o_byte = 8'h00;
            endcase
        end else begin
            case (i_idx)
                5'd0:    o_byte = c_esc;
                5'd1:    o_byte = c_lbr;
                5'd2:    o_byte = (i_cmd == CMD_LINE1) ? c_row1 : c_row2;
                5'd3:    o_byte = c_semi;
                5'd4:    o_byte = c_col0;
                5'd5:    o_byte = c_home;
                default: o_byte = 8'h00;
            endcase
            // Text follows the cursor-home header, leftmost character first.
            for (int i = 0; i < parm_line_len; i++) begin
                if (i_idx == 5'(c_hdr_len_line + i))
                    o_byte = i_text[8*(parm_line_len-1-i) +: 8];
            end
        end
    end

endmodule

// File: rtl/lcd_cls_cmd_sequencer.sv
// Serialises clear / line-write requests into PMOD CLS escape sequences, one byte per
// valid/ready transfer, with fixed inter-byte gaps and a drain wait before going idle.
module lcd_cls_cmd_sequencer
    import lcd_cls_pkg::*;
#(
    parameter int parm_line_len = 16,
    parameter int parm_byte_gap = 4
) (
    input  logic                         i_clk_20mhz,
    input  logic                         i_rst_20mhz,
    input  logic                         i_ce_2_5mhz,
    input  logic                         i_lcd_wr_clear_display,
    input  logic                         i_lcd_wr_text_line1,
    input  logic                         i_lcd_wr_text_line2,
    input  logic [8*parm_line_len-1:0]   i_dat_ascii_line1,
    input  logic [8*parm_line_len-1:0]   i_dat_ascii_line2,
    output logic                         o_lcd_command_ready,
    lcd_cls_cmd_sequencer_if.master      tx
);

    localparam int GW = (parm_byte_gap > 0) ? $clog2(parm_byte_gap + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((parm_byte_gap > 0) ? parm_byte_gap - 1 : 0);

    t_cls_seq_state              state_q, state_d;
    t_cls_cmd                    cmd_q, cmd_d;
    logic [8*parm_line_len-1:0]  text_q, text_d;
    logic [4:0]                  idx_q, idx_d;
    logic [GW-1:0]               gap_q, gap_d;
    logic [7:0]                  rom_byte;
    logic [4:0]                  last_idx;

    lcd_cls_seq_rom #(.parm_line_len(parm_line_len)) u_rom (
        .i_cmd  (cmd_q),
        .i_idx  (idx_q),
        .i_text (text_q),
        .o_byte (rom_byte)
    );

    assign last_idx            = seq_last_idx(cmd_q, parm_line_len);
    assign o_lcd_command_ready = (state_q == ST_IDLE);
    assign tx.tx_valid         = (state_q == ST_SEND);
    // Byte is a function of registered cmd/idx/text only, so it holds while awaiting ready.
    assign tx.tx_byte          = (state_q == ST_SEND) ? rom_byte : 8'h00;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        text_d  = text_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        if (i_ce_2_5mhz) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_lcd_wr_clear_display) begin
                        cmd_d   = CMD_CLEAR;
                        idx_d   = '0;
                        gap_d   = '0;
                        state_d = ST_SEND;
                    end else if (i_lcd_wr_text_line1) begin
                        cmd_d   = CMD_LINE1;
                        text_d  = i_dat_ascii_line1;
                        idx_d   = '0;
                        gap_d   = '0;
                        state_d = ST_SEND;
                    end else if (i_lcd_wr_text_line2) begin
                        cmd_d   = CMD_LINE2;
                        text_d  = i_dat_ascii_line2;
                        idx_d   = '0;
                        gap_d   = '0;
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx.tx_ready) begin
                        if (idx_q == last_idx) begin
                            state_d = ST_DRAIN;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            gap_d   = '0;
                            state_d = (parm_byte_gap == 0) ? ST_SEND : ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = ST_SEND;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (tx.tx_idle)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_CLEAR;
            text_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            text_q  <= text_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

endmodule
